// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters advanced on rising edges of a
// divided pixel-clock strobe, with sync/visible decode and line/frame pulses.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pix_clk_div,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit decode constants so a 1024-wide timing still compares correctly.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_q;
  logic       tick;
  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [10:0] x_ext;
  logic [10:0] y_ext;

  always_comb begin
    x_ext  = {1'b0, x_q};
    y_ext  = {1'b0, y_q};
    tick   = pix_clk_div & ~pix_q;
    x_wrap = tick && (x_ext == H_LAST);
    y_wrap = x_wrap && (y_ext == V_LAST);
  end

  // Reset wins over any tick, so a wrap coinciding with reset never pulses.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pix_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_q       <= pix_clk_div;
      line_start  <= x_wrap;
      frame_start <= y_wrap;
      if (tick) begin
        if (x_wrap) begin
          x_q <= '0;
          y_q <= y_wrap ? '0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  always_comb begin
    x        = x_q;
    y        = y_q;
    hsync    = ~((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END));
    vsync    = ~((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END));
    video_on = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-timing instance for line-level
// behaviour and a tiny-timing instance (15 x 8) for whole-frame behaviour.
module tb_vga_sync_gen;

  logic       clk_in;
  logic       reset;
  logic       pix_clk_div;
  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;
  logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
  logic [9:0] x_s, y_s;

  int errors = 0;
  int checks = 0;
  int ls_cnt, fs_cnt, ls_s_cnt, fs_s_cnt, both_s_cnt;
  int tick_no;
  int fs_s_tick[$];

  vga_sync_gen dut (
    .clk_in(clk_in), .reset(reset), .pix_clk_div(pix_clk_div),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  // Small timing: H 8+2+3+2 = 15, hsync low x=10..12; V 4+1+2+1 = 8, vsync low y=5..6.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk_in(clk_in), .reset(reset), .pix_clk_div(pix_clk_div),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
    .x(x_s), .y(y_s), .line_start(line_start_s), .frame_start(frame_start_s)
  );

  // Clock and reset defaults
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Driver tasks: drive pix_clk_div, take one edge, observe 1 ns later.
  task automatic step(input logic v);
    pix_clk_div = v;
    @(posedge clk_in);
    #1;
    if (line_start) ls_cnt++;
    if (frame_start) fs_cnt++;
    if (line_start_s) ls_s_cnt++;
    if (frame_start_s) begin
      fs_s_cnt++;
      fs_s_tick.push_back(tick_no);
    end
    if (line_start_s && frame_start_s) both_s_cnt++;
  endtask

  task automatic tick4();
    tick_no++;
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
  endtask

  task automatic clear_counts();
    ls_cnt = 0; fs_cnt = 0; ls_s_cnt = 0; fs_s_cnt = 0; both_s_cnt = 0;
    tick_no = 0;
    fs_s_tick.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0); step(1'b0);
    reset = 1'b0;
    step(1'b0);
    clear_counts();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x); end
    if (y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
    if (line_start !== 1'b0) begin errors++; $display("FAIL reset_ls: got %b expected 0", line_start); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    if (video_on !== 1'b1) begin errors++; $display("FAIL reset_video_on: got %b expected 1", video_on); end
    if (x_s !== 10'd0) begin errors++; $display("FAIL reset_x_s: got %0d expected 0", x_s); end
  endtask

  task automatic test_count();
    int bad = 0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      if (x !== 10'(i)) bad++;
      step(1'b1); if (x !== 10'(i)) bad++;
      step(1'b0); if (x !== 10'(i)) bad++;
      step(1'b0); if (x !== 10'(i)) bad++;
    end
    chk("count_step_errors", bad, 0);
    chk("count_x", int'(x), 10);
    chk("count_y", int'(y), 0);
  endtask

  task automatic test_line();
    int xbad = 0, ybad = 0, vbad = 0, hs_low = 0, vid = 0;
    int hs_first = -1, hs_last = -1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (x !== 10'(i)) xbad++;
      if (y !== 10'd0) ybad++;
      if (vsync !== 1'b1) vbad++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (video_on === 1'b1) vid++;
      if (i == 799) chk("line_ls_before_wrap", ls_cnt, 0);
      tick4();
    end
    chk("line_x_seq", xbad, 0);
    chk("line_y_hold", ybad, 0);
    chk("line_vsync_high", vbad, 0);
    chk("line_hsync_low_ticks", hs_low, 96);
    chk("line_hsync_first", hs_first, 656);
    chk("line_hsync_last", hs_last, 751);
    chk("line_video_on_ticks", vid, 640);
    chk("wrap_x", int'(x), 0);
    chk("wrap_y", int'(y), 1);
    chk("wrap_line_start_cycles", ls_cnt, 1);
    chk("wrap_frame_start_cycles", fs_cnt, 0);
  endtask

  task automatic test_frame();
    int xbad = 0, ybad = 0, vbad = 0, vs_low = 0;
    int ex = 0, ey = 0;
    logic exp_vs;
    do_reset();
    for (int t = 0; t < 240; t++) begin
      if (x_s !== 10'(ex)) xbad++;
      if (y_s !== 10'(ey)) ybad++;
      exp_vs = !(ey == 5 || ey == 6);
      if (vsync_s !== exp_vs) vbad++;
      if (vsync_s === 1'b0) vs_low++;
      tick4();
      if (ex == 14) begin
        ex = 0;
        ey = (ey == 7) ? 0 : ey + 1;
      end else begin
        ex++;
      end
    end
    chk("frame_x_seq", xbad, 0);
    chk("frame_y_seq", ybad, 0);
    chk("frame_vsync_decode", vbad, 0);
    chk("frame_vsync_low_ticks", vs_low, 60);
    chk("frame_start_cycles", fs_s_cnt, 2);
    chk("frame_line_start_cycles", ls_s_cnt, 16);
    chk("frame_with_line_start", both_s_cnt, 2);
    if (fs_s_tick.size() == 2) begin
      chk("frame_first_tick", fs_s_tick[0], 120);
      chk("frame_period_ticks", fs_s_tick[1] - fs_s_tick[0], 120);
    end else begin
      chk("frame_tick_log_size", fs_s_tick.size(), 2);
    end
    chk("frame_default_no_fs", fs_cnt, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (299) tick4();
    chk("mid_x_before", int'(x), 299);
    chk("mid_xs_before", int'(x_s), 14);
    chk("mid_ys_before", int'(y_s), 3);
    clear_counts();
    // Rising pix edge coincides with reset and with the small instance's wrap.
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("mid_x_after", int'(x), 0);
    chk("mid_y_after", int'(y), 0);
    chk("mid_xs_after", int'(x_s), 0);
    chk("mid_ys_after", int'(y_s), 0);
    step(1'b0); step(1'b0);
    chk("mid_no_line_start", ls_cnt + ls_s_cnt, 0);
    chk("mid_no_frame_start", fs_cnt + fs_s_cnt, 0);
  endtask

  task automatic test_stuck();
    int bad = 0;
    int hi_len[8] = '{1, 1, 1, 3, 3, 2, 1, 4};
    int lo_len[8] = '{1, 2, 1, 1, 3, 1, 1, 1};
    do_reset();
    repeat (3) tick4();
    chk("stuck_x_start", int'(x), 3);
    step(1'b1);
    chk("stuck_first_rise", int'(x), 4);
    repeat (49) begin step(1'b1); if (x !== 10'd4) bad++; end
    repeat (20) begin step(1'b0); if (x !== 10'd4) bad++; end
    chk("stuck_frozen", bad, 0);
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < hi_len[k]; h++) step(1'b1);
      chk($sformatf("duty_rise_%0d", k), int'(x), 5 + k);
      for (int l = 0; l < lo_len[k]; l++) step(1'b0);
    end
    chk("duty_final_x", int'(x), 12);
    chk("duty_y", int'(y), 0);
  endtask

  initial begin
    reset = 1'b1;
    pix_clk_div = 1'b0;
    clear_counts();
    test_reset();
    test_count();
    test_line();
    test_frame();
    test_reset_mid();
    test_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
